ptw: RTL and testbench

Single-entry page-table walker that refills the MMU translation register on a miss. It watches the MMU error output, reads the page-table entry for the faulting virtual page from memory over a req/ack port, and drives the MMU update interface (`vpage_in`, `ppage_in`, `mmu_update`, `mmu_en`) with the result. If the entry is invalid, it signals a page fault to the CU instead. It sits between the MMU, the data-memory arbiter and the CU stall logic.

---
 rtl/ptw_pkg.sv | 16 +
 rtl/ptw_if.sv | 16 +
 rtl/ptw.sv | 105 ++++++++++
 tb/tb_ptw.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// Shared definitions for the page-table walker: FSM state encoding and
// default geometry, kept in step with the MMU.
package ptw_pkg;

  localparam int unsigned PTW_ADDR_W         = 32;
  localparam int unsigned PTW_PAGE_NUM_WIDTH = 20;
  localparam int unsigned PTW_PTE_V_BIT      = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

endpackage : ptw_pkg

// File: rtl/ptw_if.sv
// PTE read port between the walker (master) and the data-memory arbiter (slave).
//   req   : read request, held until ack
//   addr  : PTE address, stable while req is high
//   ack   : read complete, rdata valid in the same cycle
//   rdata : PTE data
interface ptw_if import ptw_pkg::*;;

  logic                  req;
  logic [PTW_ADDR_W-1:0] addr;
  logic                  ack;
  logic [PTW_ADDR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface : ptw_if

// File: rtl/ptw.sv
// Single-entry page-table walker. On an MMU miss it reads the PTE for the
// faulting virtual page and either refills the MMU translation register or
// raises a page fault to the CU.
//   clk, clr_n   : clock, asynchronous active-low reset
//   miss         : MMU translation error for the current access
//   miss_vaddr   : virtual address that missed
//   pt_base      : page-table base (physical, word aligned)
//   flush        : pipeline clear, abandons the walk
//   mem          : PTE read port (req/addr out, ack/rdata in)
//   vpage_o      : MMU vpage_in
//   ppage_o      : MMU ppage_in
//   mmu_update_o : one-cycle update pulse to the MMU
//   mmu_en_o     : MMU enable, high with mmu_update_o
//   fault_o      : one-cycle page-fault pulse to the CU
//   stall_o      : pipeline stall request (combinational from miss)
module ptw
  import ptw_pkg::*;
#(
  parameter int unsigned PAGE_NUM_WIDTH = PTW_PAGE_NUM_WIDTH,
  parameter int unsigned PTE_V_BIT      = PTW_PTE_V_BIT
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      miss,
  input  logic [PTW_ADDR_W-1:0]     miss_vaddr,
  input  logic [PTW_ADDR_W-1:0]     pt_base,
  input  logic                      flush,
  ptw_if.master                     mem,
  output logic [PAGE_NUM_WIDTH-1:0] vpage_o,
  output logic [PAGE_NUM_WIDTH-1:0] ppage_o,
  output logic                      mmu_update_o,
  output logic                      mmu_en_o,
  output logic                      fault_o,
  output logic                      stall_o
);

  state_e                    state_q;
  logic [PAGE_NUM_WIDTH-1:0] vpage_q;
  logic [PAGE_NUM_WIDTH-1:0] pte_q;    // only the PPN field of the PTE is kept
  logic [PTW_ADDR_W-1:0]     addr_q;
  logic                      req_q;
  logic                      drop_q;

  logic [PAGE_NUM_WIDTH-1:0] vpage_d;
  logic [PTW_ADDR_W-1:0]     addr_d;
  logic                      unused_bits;

  // PTE address from the page number of the incoming miss; wraps modulo 2^32.
  assign vpage_d = miss_vaddr[PTW_ADDR_W-1 -: PAGE_NUM_WIDTH];
  assign addr_d  = pt_base + PTW_ADDR_W'({vpage_d, 2'b00});

  assign unused_bits = ^{miss_vaddr[PTW_ADDR_W-1-PAGE_NUM_WIDTH:0], mem.rdata};

  // Walk FSM and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      vpage_q <= '0;
      pte_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss && !flush) begin
            vpage_q <= vpage_d;
            addr_q  <= addr_d;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The request is never withdrawn; a flush only marks the result dead.
          if (flush) drop_q <= 1'b1;
          if (mem.ack) begin
            req_q  <= 1'b0;
            drop_q <= 1'b0;
            pte_q  <= mem.rdata[PAGE_NUM_WIDTH-1:0];
            if (drop_q || flush)           state_q <= ST_IDLE;
            else if (mem.rdata[PTE_V_BIT]) state_q <= ST_UPDATE;
            else                           state_q <= ST_FAULT;
          end
        end
        ST_UPDATE: state_q <= ST_IDLE;
        ST_FAULT:  state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.req  = req_q;
  assign mem.addr = addr_q;
  assign vpage_o  = vpage_q;
  assign ppage_o  = pte_q;

  // Pulses come straight from the state register; a flush in that same
  // cycle must still be able to kill them, hence the gating.
  assign mmu_update_o = (state_q == ST_UPDATE) & ~flush;
  assign mmu_en_o     = mmu_update_o;
  assign fault_o      = (state_q == ST_FAULT) & ~flush;

  assign stall_o = (state_q != ST_IDLE) | (miss & ~flush);

endmodule : ptw

// File: tb/tb_ptw.sv
module tb_ptw;

  logic        clk;
  logic        clr_n;
  logic        miss;
  logic [31:0] miss_vaddr;
  logic [31:0] pt_base;
  logic        flush;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [19:0] vpage_o;
  logic [19:0] ppage_o;
  logic        mmu_update_o;
  logic        mmu_en_o;
  logic        fault_o;
  logic        stall_o;

  int checks;
  int errors;

  ptw_if mem_bus ();

  assign mem_bus.ack   = mem_ack;
  assign mem_bus.rdata = mem_rdata;

  ptw #(.PAGE_NUM_WIDTH(20), .PTE_V_BIT(31)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .miss         (miss),
    .miss_vaddr   (miss_vaddr),
    .pt_base      (pt_base),
    .flush        (flush),
    .mem          (mem_bus),
    .vpage_o      (vpage_o),
    .ppage_o      (ppage_o),
    .mmu_update_o (mmu_update_o),
    .mmu_en_o     (mmu_en_o),
    .fault_o      (fault_o),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  // Outcome of a walk: 0 none, 1 update, 2 fault.
  typedef struct {
    string       tag;
    logic [31:0] base;
    logic [31:0] vaddr;
    logic [31:0] rdata;
    int          wt;     // REQ cycles before the ack cycle
    int          fc;     // cycle index carrying flush, -1 for none
    logic [31:0] e_addr;
    int          e_kind;
    logic [19:0] e_vp;
    logic [19:0] e_pp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle 0 presents the miss, cycles 1..wt+1 are REQ (ack in the last),
  // cycle wt+2 carries the pulse, cycle wt+3 must be idle again.
  task automatic run_walk(input vec_t v);
    bit drop_req;
    bit e_stall, e_req, e_upd, e_flt;
    drop_req = (v.fc >= 1) && (v.fc <= v.wt + 1);
    for (int k = 0; k <= v.wt + 3; k++) begin
      @(posedge clk);
      #1;
      miss       = (k <= v.wt + 1);
      miss_vaddr = v.vaddr;
      pt_base    = v.base;
      flush      = (k == v.fc);
      mem_ack    = (k == v.wt + 1);
      mem_rdata  = mem_ack ? v.rdata : $urandom();
      #1;
      e_stall = (k <= v.wt + 1) || ((k == v.wt + 2) && !drop_req);
      e_req   = (k >= 1) && (k <= v.wt + 1);
      e_upd   = (k == v.wt + 2) && (v.e_kind == 1);
      e_flt   = (k == v.wt + 2) && (v.e_kind == 2);
      chk($sformatf("%s.c%0d.stall", v.tag, k), 32'(stall_o), 32'(e_stall));
      chk($sformatf("%s.c%0d.req", v.tag, k), 32'(mem_bus.req), 32'(e_req));
      if (e_req) chk($sformatf("%s.c%0d.addr", v.tag, k), mem_bus.addr, v.e_addr);
      chk($sformatf("%s.c%0d.update", v.tag, k), 32'(mmu_update_o), 32'(e_upd));
      chk($sformatf("%s.c%0d.en", v.tag, k), 32'(mmu_en_o), 32'(e_upd));
      chk($sformatf("%s.c%0d.fault", v.tag, k), 32'(fault_o), 32'(e_flt));
      if (e_upd) begin
        chk($sformatf("%s.vpage", v.tag), 32'(vpage_o), 32'(v.e_vp));
        chk($sformatf("%s.ppage", v.tag), 32'(ppage_o), 32'(v.e_pp));
      end
    end
    miss  = 1'b0;
    flush = 1'b0;
  endtask

  // Reference: PTE address and outcome from the walker's rules.
  function automatic vec_t model(input string tag, input logic [31:0] base, input logic [31:0] vaddr,
                                 input logic [31:0] rdata, input int wt, input int fc);
    vec_t v;
    v.tag    = tag;
    v.base   = base;
    v.vaddr  = vaddr;
    v.rdata  = rdata;
    v.wt     = wt;
    v.fc     = fc;
    v.e_addr = base + (vaddr >> 12) * 32'd4;
    v.e_vp   = vaddr[31:12];
    v.e_pp   = rdata[19:0];
    if ((fc >= 1) && (fc <= wt + 2)) v.e_kind = 0;
    else                             v.e_kind = rdata[31] ? 1 : 2;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    clr_n      = 1'b0;
    miss       = 1'b0;
    miss_vaddr = '0;
    pt_base    = '0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;

    tbl[0] = '{"valid0",  32'h0000_1000, 32'h0040_3ABC, 32'h8000_0123, 0, -1, 32'h0000_200C, 1, 20'h00403, 20'h00123};
    tbl[1] = '{"invalid", 32'h0000_1000, 32'h0040_3ABC, 32'h0000_0123, 0, -1, 32'h0000_200C, 2, 20'h00403, 20'h00123};
    tbl[2] = '{"wait5",   32'h0000_1000, 32'h0040_3ABC, 32'h8000_0456, 5, -1, 32'h0000_200C, 1, 20'h00403, 20'h00456};
    tbl[3] = '{"flushreq",32'h0000_1000, 32'h0040_3ABC, 32'h8000_0456, 3,  2, 32'h0000_200C, 0, 20'h00403, 20'h00456};
    tbl[4] = '{"wrap",    32'hFFFF_FFF0, 32'h0000_5000, 32'h8ABC_DEF0, 1, -1, 32'h0000_0004, 1, 20'h00005, 20'hCDEF0};
    tbl[5] = '{"flushupd",32'h0000_1000, 32'h0040_3ABC, 32'h8000_0123, 0,  2, 32'h0000_200C, 0, 20'h00403, 20'h00123};
    tbl[6] = '{"topvpn",  32'h0000_0000, 32'hFFFF_F000, 32'h8000_0000, 2, -1, 32'h003F_FFFC, 1, 20'hFFFFF, 20'h00000};

    // Reset state.
    #12;
    chk("rst.req", 32'(mem_bus.req), 32'd0);
    chk("rst.addr", mem_bus.addr, 32'd0);
    chk("rst.vpage", 32'(vpage_o), 32'd0);
    chk("rst.ppage", 32'(ppage_o), 32'd0);
    chk("rst.update", 32'(mmu_update_o), 32'd0);
    chk("rst.en", 32'(mmu_en_o), 32'd0);
    chk("rst.fault", 32'(fault_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 7; i++) run_walk(tbl[i]);

    // Flush in IDLE blocks the walk from starting.
    @(posedge clk);
    #1;
    miss       = 1'b1;
    flush      = 1'b1;
    miss_vaddr = 32'h0012_3000;
    #1;
    chk("idleflush.stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    miss  = 1'b0;
    flush = 1'b0;
    #1;
    chk("idleflush.req", 32'(mem_bus.req), 32'd0);
    chk("idleflush.stall2", 32'(stall_o), 32'd0);

    // Asynchronous reset in the middle of a REQ.
    @(posedge clk);
    #1;
    miss       = 1'b1;
    miss_vaddr = 32'h00AB_C123;
    pt_base    = 32'h0000_4000;
    mem_ack    = 1'b0;
    #1;
    chk("arst.stall0", 32'(stall_o), 32'd1);
    @(posedge clk);
    #2;
    chk("arst.req_before", 32'(mem_bus.req), 32'd1);
    chk("arst.addr_before", mem_bus.addr, 32'h0000_6AF0);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    miss  = 1'b0;
    #1;
    chk("arst.req", 32'(mem_bus.req), 32'd0);
    chk("arst.addr", mem_bus.addr, 32'd0);
    chk("arst.vpage", 32'(vpage_o), 32'd0);
    chk("arst.ppage", 32'(ppage_o), 32'd0);
    chk("arst.update", 32'(mmu_update_o), 32'd0);
    chk("arst.fault", 32'(fault_o), 32'd0);
    chk("arst.stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    run_walk(model("postrst", 32'h0000_4000, 32'h00AB_C123, 32'h8001_2345, 1, -1));

    // Randomized walks against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] base;
      int          wt;
      int          fc;
      base = $urandom() & 32'hFFFF_FFFC;
      wt   = int'($urandom_range(0, 4));
      fc   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32'(wt + 2))) : -1;
      run_walk(model($sformatf("rnd%0d", i), base, $urandom(), $urandom(), wt, fc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ptw
